// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the cpu_bus responder: region decode constants,
// bus reset value and the posted I/O write entry layout.
package cpu_bus_pkg;

   localparam logic [15:0] RAM_MASK = 16'hE000;
   localparam logic [15:0] RAM_BASE = 16'h0000;
   localparam logic [15:0] IO_MASK  = 16'hE000;
   localparam logic [15:0] IO_BASE  = 16'h2000;
   localparam logic [15:0] ROM_MASK = 16'h8000;
   localparam logic [15:0] ROM_BASE = 16'h8000;

   localparam logic [7:0]  BUS_RESET_VAL = 8'hFF;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } io_entry_t;

   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/io_wfifo.sv
// Generic synchronous FIFO with push, pop, full, empty and level.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module io_wfifo #(
   parameter int DEPTH = 4,
   parameter int W     = 11,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = PW + 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign head_data = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/cpu_bus.sv
// 6502 bus responder: mirrored work RAM, cartridge ROM port and a posted-write
// I/O window. Optional CPU_BUS_OPENBUS_EN returns the last bus byte on open-bus reads.
module cpu_bus
   import cpu_bus_pkg::*;
#(
   parameter int RAM_AW     = 11,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic [15:0]                   cpu_addr,
   input  logic [7:0]                    cpu_wdata,
   input  logic                          cpu_wren,
   input  logic                          cpu_read,
   output logic [7:0]                    cpu_rdata,
   output logic [14:0]                   rom_addr,
   input  logic [7:0]                    rom_data,
   output logic [2:0]                    io_addr,
   output logic [7:0]                    io_wdata,
   output logic                          io_we,
   input  logic                          io_ready,
   output logic                          io_rd,
   input  logic [7:0]                    io_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          io_err,
   input  logic                          err_clr
);

   logic              is_ram, is_io, is_rom;
   logic [RAM_AW-1:0] ram_idx;
   logic [7:0]        ram_mem [2**RAM_AW];
   logic [7:0]        ram_rdata_q;
   logic [7:0]        open_bus;

   io_entry_t         push_entry, head_entry;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic              push_drop, rd_blocked;
   logic              io_err_q, io_err_d;

   always_comb begin
      is_ram  = in_region(cpu_addr, RAM_BASE, RAM_MASK);
      is_io   = in_region(cpu_addr, IO_BASE, IO_MASK);
      is_rom  = in_region(cpu_addr, ROM_BASE, ROM_MASK);
      ram_idx = cpu_addr[RAM_AW-1:0];
   end

   assign rom_addr = cpu_addr[14:0];

   always_ff @(posedge clock) begin
      if (cpu_wren && is_ram) ram_mem[ram_idx] <= cpu_wdata;
   end

   // Falling-edge read gives same-cycle data to the CPU before the next rising edge.
   always_ff @(negedge clock) begin
      ram_rdata_q <= ram_mem[ram_idx];
   end

`ifdef CPU_BUS_OPENBUS_EN
   logic [7:0] last_data_q, last_data_d;

   always_comb begin
      last_data_d = cpu_wren ? cpu_wdata : cpu_rdata;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) last_data_q <= BUS_RESET_VAL;
      else         last_data_q <= last_data_d;
   end

   assign open_bus = last_data_q;
`else
   assign open_bus = BUS_RESET_VAL;
`endif

   always_comb begin
      push_entry.addr = cpu_addr[2:0];
      push_entry.data = cpu_wdata;
      fifo_push       = cpu_wren && is_io;
      fifo_pop        = !fifo_empty && io_ready;
      push_drop       = fifo_push && fifo_full && !fifo_pop;
   end

   io_wfifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(io_entry_t))
   ) u_io_wfifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // A side-effect read may only reach the peripheral once all posted writes have drained.
   always_comb begin
      io_rd      = is_io && cpu_read && fifo_empty;
      rd_blocked = is_io && cpu_read && !fifo_empty;
      if (is_ram)     cpu_rdata = ram_rdata_q;
      else if (is_rom) cpu_rdata = rom_data;
      else if (io_rd)  cpu_rdata = io_rdata;
      else             cpu_rdata = open_bus;
   end

   always_comb begin
      io_we    = !fifo_empty;
      io_wdata = head_entry.data;
      io_addr  = io_rd ? cpu_addr[2:0] : head_entry.addr;
   end

   always_comb begin
      io_err_d = io_err_q;
      if (err_clr)                       io_err_d = 1'b0;
      else if (push_drop || rd_blocked)  io_err_d = 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) io_err_q <= 1'b0;
      else         io_err_q <= io_err_d;
   end

   assign io_err = io_err_q;

endmodule
